// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: serves word loads/stores from an internal
// array with a fixed wait latency, freezing the pipeline via memStall while pending.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        memReady,
    output logic        memStall,
    output logic        memError
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic          r_wr;
    logic          r_err;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_bad;
    logic          w_access;
    logic          w_ready;

    assign w_req    = memRead | memWrite;
    // Misaligned, out-of-range and read+write requests are all judged at acceptance.
    assign w_bad    = (address[1:0] != 2'b00) || ({1'b0, address} >= LIMIT) ||
                      (memRead && memWrite);
    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_ready  = (r_state == S_DONE);

    assign readData = r_rdata;
    assign memReady = w_ready;
    assign memError = w_ready & r_err;
    assign memStall = w_req & ~w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_cnt   <= CW'(LATENCY - 1);
                r_rd    <= memRead;
                r_wr    <= memWrite;
                r_err   <= w_bad;
                r_idx   <= address[AW+1:2];
                r_wdata <= writeData;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_access && r_rd) begin
                r_rdata <= r_err ? 32'd0 : r_mem[r_idx];
            end
        end
    end

    // The array has no reset; an aborted store never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (w_access && r_wr && !r_err) begin
            r_mem[r_idx] <= r_wdata;
        end
    end
endmodule
